// File: rtl/mul_pipe_unit.sv
// Pipelined RV M-extension multiplier (MUL/MULH/MULHSU/MULHU) with tag passthrough, STAGES cycles of latency.
// Global stall: all stages hold while out_valid && !out_ready, so in_ready drops in the same cycle; flush clears every stage.
module mul_pipe_unit #(
    parameter int XLEN   = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int PW = 2 * XLEN;

    typedef enum logic [1:0] {
        SEL_LO   = 2'd0,
        SEL_HI   = 2'd1,
        SEL_ZERO = 2'd2
    } sel_t;

    logic             advance;
    logic             accept;
    logic             sign_a;
    logic             sign_b;
    logic [PW-1:0]    a_wide;
    logic [PW-1:0]    b_wide;
    logic [PW-1:0]    prod;
    sel_t             sel_in;

    logic [STAGES-1:0] vld;
    logic [TAG_W-1:0]  tag_q  [STAGES];
    sel_t              sel_q  [STAGES];
    logic [PW-1:0]     prod_q [STAGES];

    assign advance = !out_valid || out_ready;
    assign in_ready = advance && !reset;
    assign accept = in_valid && in_ready && !flush;

    // Widening straight to 2*XLEN with the chosen extension gives the same low
    // 2*XLEN bits as the signed (XLEN+1)x(XLEN+1) product.
    always_comb begin
        sign_a = (in_funct3 == 3'b001) || (in_funct3 == 3'b010);
        sign_b = (in_funct3 == 3'b001);
        a_wide = {{XLEN{sign_a & in_a[XLEN-1]}}, in_a};
        b_wide = {{XLEN{sign_b & in_b[XLEN-1]}}, in_b};
        prod   = a_wide * b_wide;
        if (in_funct3[2]) begin
            sel_in = SEL_ZERO;
        end else if (in_funct3[1:0] == 2'b00) begin
            sel_in = SEL_LO;
        end else begin
            sel_in = SEL_HI;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
            for (int i = 0; i < STAGES; i++) begin
                tag_q[i]  <= '0;
                sel_q[i]  <= SEL_LO;
                prod_q[i] <= '0;
            end
        end else begin
            if (flush) begin
                vld <= '0;
            end else if (advance) begin
                vld[0] <= accept;
                for (int i = 1; i < STAGES; i++) begin
                    vld[i] <= vld[i-1];
                end
            end
            // Data only moves on advance so a stalled output stays stable.
            if (advance) begin
                if (accept) begin
                    tag_q[0]  <= in_tag;
                    sel_q[0]  <= sel_in;
                    prod_q[0] <= prod;
                end
                for (int i = 1; i < STAGES; i++) begin
                    tag_q[i]  <= tag_q[i-1];
                    sel_q[i]  <= sel_q[i-1];
                    prod_q[i] <= prod_q[i-1];
                end
            end
        end
    end

    always_comb begin
        out_result = '0;
        case (sel_q[STAGES-1])
            SEL_LO:  out_result = prod_q[STAGES-1][XLEN-1:0];
            SEL_HI:  out_result = prod_q[STAGES-1][PW-1:XLEN];
            default: out_result = '0;
        endcase
    end

    assign out_valid = vld[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign busy      = |vld;

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Scoreboard bench for mul_pipe_unit: directed vectors, queue of expected tag/result/due-cycle, decoupled monitor.
module tb_mul_pipe_unit;

    localparam int STG = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_funct3 = 3'd0;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;
    logic [4:0]  in_tag = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        busy;

    logic        flush_x = 1'b0;
    logic        ordy_x = 1'b1;

    logic        v64 = 1'b0;
    logic [2:0]  f64 = 3'd0;
    logic [63:0] a64 = 64'd0;
    logic [63:0] b64 = 64'd0;
    logic [4:0]  t64 = 5'd0;
    logic        rdy64, ov64, busy64;
    logic [63:0] res64;
    logic [4:0]  tag64;

    logic        v8 = 1'b0;
    logic [2:0]  f8 = 3'd0;
    logic [31:0] a8 = 32'd0;
    logic [31:0] b8 = 32'd0;
    logic [4:0]  t8 = 5'd0;
    logic        rdy8, ov8, busy8;
    logic [31:0] res8;
    logic [4:0]  tag8;

    mul_pipe_unit #(.XLEN(32), .STAGES(STG), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .busy(busy)
    );

    mul_pipe_unit #(.XLEN(64), .STAGES(1), .TAG_W(5)) dut64 (
        .clk(clk), .reset(reset), .flush(flush_x),
        .in_valid(v64), .in_ready(rdy64), .in_funct3(f64),
        .in_a(a64), .in_b(b64), .in_tag(t64),
        .out_valid(ov64), .out_ready(ordy_x),
        .out_result(res64), .out_tag(tag64), .busy(busy64)
    );

    mul_pipe_unit #(.XLEN(32), .STAGES(8), .TAG_W(5)) dut8 (
        .clk(clk), .reset(reset), .flush(flush_x),
        .in_valid(v8), .in_ready(rdy8), .in_funct3(f8),
        .in_a(a8), .in_b(b8), .in_tag(t8),
        .out_valid(ov8), .out_ready(ordy_x),
        .out_result(res8), .out_tag(tag8), .busy(busy8)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // Directed stream vectors with hand-computed results.
    logic [2:0]  sf [10] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b000,
                             3'b001, 3'b101, 3'b011, 3'b001, 3'b000};
    logic [31:0] sa [10] = '{32'd3, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h00010000,
                             32'h7FFFFFFF, 32'h00001234, 32'h12345678, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] sb [10] = '{32'd5, 32'hFFFFFFFF, 32'd2, 32'd2, 32'h00010000,
                             32'h7FFFFFFF, 32'h00005678, 32'h00000010, 32'd1, 32'hFFFFFFFF};
    logic [31:0] sr [10] = '{32'h0000000F, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h00000000,
                             32'h3FFFFFFF, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h00000001};

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the handshake.
    task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t, input logic [31:0] r,
                        input bit push, input bit lat, input bit need_rdy);
        int  tries = 0;
        bit  done = 1'b0;
        in_valid = 1'b1; in_funct3 = f; in_a = a; in_b = b; in_tag = t;
        while (!done) begin
            @(negedge clk);
            if (need_rdy && tries == 0) check("in_ready_send", 64'(in_ready), 64'd1);
            if (in_ready && !flush) begin
                done = 1'b1;
                if (push) q.push_back('{tag: t, res: r, due: (lat ? cyc + STG : -1)});
            end
            tries++;
            if (!done && tries > 50) begin
                checks++; failures++;
                $display("FAIL send_timeout: tag %0d never accepted", t);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_output: tag %0d result %h, none expected", out_tag, out_result);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out_tag", 64'(out_tag), 64'(e.tag));
                check("out_result", 64'(out_result), 64'(e.res));
                if (e.due >= 0) check("latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] hold_r;
        logic [4:0]  hold_t;
        int          c0;
        int          w;

        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rel_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Single ops with fixed latency.
        send(3'b000, 32'd7,        32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 1, 1, 1); idle(5);
        send(3'b001, 32'h80000000, 32'h80000000, 5'd2, 32'h40000000, 1, 1, 1); idle(5);
        send(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, 1, 1, 1); idle(5);
        send(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFE, 1, 1, 1); idle(5);
        send(3'b100, 32'h12345678, 32'h9ABCDEF0, 5'd5, 32'h00000000, 1, 1, 1); idle(5);

        // Back-to-back stream; due cycles prove consecutive outputs.
        for (int i = 0; i < 10; i++) send(sf[i], sa[i], sb[i], 5'(i), sr[i], 1, 1, 1);
        idle(6);

        // Backpressure: 4-cycle stall in the middle of a 6-op stream.
        fork
            begin
                for (int i = 0; i < 6; i++) send(sf[i], sa[i], sb[i], 5'(20 + i), sr[i], 1, 0, 0);
                idle(1);
            end
            begin
                w = 0;
                do begin @(negedge clk); w++; end while (!out_valid && w < 20);
                @(posedge clk); #1;
                out_ready = 1'b0;
                @(negedge clk);
                hold_r = out_result;
                hold_t = out_tag;
                check("bp_valid_held", 64'(out_valid), 64'd1);
                check("bp_in_ready", 64'(in_ready), 64'd0);
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready", 64'(in_ready), 64'd0);
                    check("bp_result_stable", 64'(out_result), 64'(hold_r));
                    check("bp_tag_stable", 64'(out_tag), 64'(hold_t));
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
                @(negedge clk);
                check("bp_in_ready_back", 64'(in_ready), 64'd1);
            end
        join
        idle(12);
        check("bp_drained", 64'(q.size()), 64'd0);

        // Flush: oldest op is handshaken in the flush cycle, the other two die.
        send(3'b000, 32'd2, 32'd3, 5'd10, 32'd6, 1, 1, 1);
        send(3'b000, 32'd4, 32'd5, 5'd11, 32'd20, 0, 0, 1);
        send(3'b000, 32'd6, 32'd7, 5'd12, 32'd42, 0, 0, 1);
        in_valid = 1'b1; in_funct3 = 3'b000; in_a = 32'd9; in_b = 32'd9; in_tag = 5'd13;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        send(3'b000, 32'd11, 32'd13, 5'd14, 32'd143, 1, 1, 1);
        idle(6);

        // Reset with two ops in flight, head stalled at the output.
        out_ready = 1'b0;
        send(3'b000, 32'd3, 32'd3, 5'd15, 32'd9, 0, 0, 1);
        send(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd16, 32'hFFFFFFFE, 0, 0, 1);
        idle(2);
        @(negedge clk);
        check("pre_rst_out_valid", 64'(out_valid), 64'd1);
        check("pre_rst_busy", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_out_result", 64'(out_result), 64'd0);
        check("mid_rst_out_tag", 64'(out_tag), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        idle(8);

        // XLEN=64, STAGES=1.
        v64 = 1'b1; f64 = 3'b011; a64 = '1; b64 = '1; t64 = 5'd3;
        @(negedge clk);
        check("p64_in_ready", 64'(rdy64), 64'd1);
        c0 = cyc;
        @(posedge clk); #1;
        v64 = 1'b0;
        w = 0;
        do begin @(negedge clk); w++; end while (!ov64 && w < 30);
        check("p64_latency", 64'(cyc - c0), 64'd1);
        check("p64_result", res64, 64'hFFFFFFFFFFFFFFFE);
        check("p64_tag", 64'(tag64), 64'd3);
        check("p64_busy", 64'(busy64), 64'd1);
        @(posedge clk); #1;

        // XLEN=32, STAGES=8.
        v8 = 1'b1; f8 = 3'b000; a8 = 32'd7; b8 = 32'hFFFFFFFD; t8 = 5'd9;
        @(negedge clk);
        check("p8_in_ready", 64'(rdy8), 64'd1);
        c0 = cyc;
        @(posedge clk); #1;
        v8 = 1'b0;
        w = 0;
        do begin @(negedge clk); w++; end while (!ov8 && w < 30);
        check("p8_latency", 64'(cyc - c0), 64'd8);
        check("p8_result", 64'(res8), 64'h00000000FFFFFFEB);
        check("p8_tag", 64'(tag8), 64'd9);
        check("p8_busy", 64'(busy8), 64'd1);
        @(posedge clk); #1;

        idle(4);
        check("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
